// File: rtl/firing_control.sv
// Per-player firing sequencer. It conditions the raw trigger into one edge per press and steps
// through the three-shot state code. It also issues reload, cooldown, shot, empty and dry-fire events.
module firing_control #(
    parameter int unsigned COOLDOWN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       round_start,
    output logic [2:0] control,
    output logic       reload_n,
    output logic       shot_fired,
    output logic       out_of_ammo,
    output logic       dry_fire
);

    // The encodings are the datapath's decode values, so the state register drives control directly.
    typedef enum logic [2:0] {
        PRELOAD = 3'b010,
        HOLD1   = 3'b000,
        SHOT1   = 3'b001,
        HOLD2   = 3'b101,
        SHOT2   = 3'b100,
        HOLD3   = 3'b110,
        SHOT3   = 3'b111,
        OUT     = 3'b011
    } state_t;

    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES);

    state_t     state;
    state_t     state_next;
    logic       s1;
    logic       s2;
    logic       d;
    logic       trig_edge;
    logic [7:0] cool;
    logic [7:0] cool_next;
    logic       entering_shot;
    logic       cool_done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= trigger;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign trig_edge = s2 & ~d;
    assign cool_done = (cool == 8'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        entering_shot = 1'b0;
        if (round_start) begin
            state_next = HOLD1;
        end else begin
            case (state)
                HOLD1: if (trig_edge && cool_done) begin
                    state_next    = SHOT1;
                    entering_shot = 1'b1;
                end
                HOLD2: if (trig_edge && cool_done) begin
                    state_next    = SHOT2;
                    entering_shot = 1'b1;
                end
                HOLD3: if (trig_edge && cool_done) begin
                    state_next    = SHOT3;
                    entering_shot = 1'b1;
                end
                SHOT1:   state_next = HOLD2;
                SHOT2:   state_next = HOLD3;
                SHOT3:   state_next = OUT;
                OUT:     state_next = OUT;
                PRELOAD: state_next = PRELOAD;
                default: state_next = PRELOAD;
            endcase
        end
    end

    always_comb begin
        cool_next = cool;
        if (round_start) begin
            cool_next = 8'd0;
        end else if (entering_shot) begin
            cool_next = COOL_LOAD;
        end else if (!cool_done) begin
            cool_next = cool - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PRELOAD;
            cool     <= 8'd0;
            reload_n <= 1'b1;
            dry_fire <= 1'b0;
        end else begin
            state    <= state_next;
            cool     <= cool_next;
            reload_n <= ~round_start;
            // A reload in the same cycle swallows the edge, so no dry-fire is reported.
            dry_fire <= (state == OUT) & trig_edge & ~round_start;
        end
    end

    assign control     = state;
    assign shot_fired  = (state == SHOT1) || (state == SHOT2) || (state == SHOT3);
    assign out_of_ammo = (state == OUT);

endmodule

// File: tb/tb_firing_control.sv
// Bench for firing_control. It pairs an ammo-count model, compared every cycle, with directed
// scenarios whose hand-derived literal expectations pin the model.
module tb_firing_control;

    localparam int COOL = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       trigger;
    logic       round_start;
    logic [2:0] control;
    logic       reload_n;
    logic       shot_fired;
    logic       out_of_ammo;
    logic       dry_fire;

    int n_checks = 0;
    int n_errors = 0;

    firing_control #(.COOLDOWN_CYCLES(COOL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .trigger     (trigger),
        .round_start (round_start),
        .control     (control),
        .reload_n    (reload_n),
        .shot_fired  (shot_fired),
        .out_of_ammo (out_of_ammo),
        .dry_fire    (dry_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state: whether a round is loaded, rounds left, whether this cycle is a shot.
    logic loaded     = 1'b0;
    int   ammo       = 3;
    logic firing     = 1'b0;
    int   m_cool     = 0;
    logic m_reload_n = 1'b1;
    logic m_dry      = 1'b0;
    logic m_e;
    logic samp[$]    = '{1'b0, 1'b0, 1'b0};

    // A press is seen when the sample two clocks old is high and the one before it was low.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loaded = 1'b0; ammo = 3; firing = 1'b0; m_cool = 0;
            m_reload_n = 1'b1; m_dry = 1'b0;
            samp = '{1'b0, 1'b0, 1'b0};
        end else begin
            m_e = samp[1] && !samp[2];
            if (round_start) begin
                loaded = 1'b1; ammo = 3; firing = 1'b0; m_cool = 0;
                m_reload_n = 1'b0; m_dry = 1'b0;
            end else begin
                m_reload_n = 1'b1;
                m_dry = loaded && !firing && ammo == 0 && m_e;
                if (firing) begin
                    firing = 1'b0;
                    m_cool = (m_cool > 0) ? m_cool - 1 : 0;
                end else if (loaded && ammo > 0 && m_e && m_cool == 0) begin
                    firing = 1'b1;
                    ammo--;
                    m_cool = COOL;
                end else begin
                    m_cool = (m_cool > 0) ? m_cool - 1 : 0;
                end
            end
            samp.push_front(trigger);
            void'(samp.pop_back());
        end
    end

    function automatic logic [2:0] model_code();
        if (!loaded) return 3'b010;
        if (firing) begin
            case (ammo)
                2:       return 3'b001;
                1:       return 3'b100;
                default: return 3'b111;
            endcase
        end
        case (ammo)
            3:       return 3'b000;
            2:       return 3'b101;
            1:       return 3'b110;
            default: return 3'b011;
        endcase
    endfunction

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("control",     8'(control),     8'(model_code()));
            check("reload_n",    8'(reload_n),    8'(m_reload_n));
            check("shot_fired",  8'(shot_fired),  8'(firing));
            check("out_of_ammo", 8'(out_of_ammo), 8'(loaded && !firing && ammo == 0));
            check("dry_fire",    8'(dry_fire),    8'(m_dry));
        end
    end

    int         shot_cnt = 0;
    logic       rec_en   = 1'b0;
    logic [2:0] rec_q[$];
    always @(negedge clk) begin
        if (shot_fired === 1'b1) shot_cnt++;
        if (rec_en && (rec_q.size() == 0 || control !== rec_q[$])) rec_q.push_back(control);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int len);
        trigger = 1'b1;
        cycles(len);
        trigger = 1'b0;
    endtask

    task automatic pulse_round_start();
        round_start = 1'b1;
        cycles(1);
        round_start = 1'b0;
    endtask

    logic [2:0] exp_seq [7] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b110, 3'b111, 3'b011};
    int s0;

    initial begin
        reset_n = 1'b0; trigger = 1'b0; round_start = 1'b0;
        cycles(3);
        check("rst_control",  8'(control),  8'h02);
        check("rst_reload_n", 8'(reload_n), 8'h01);
        check("rst_dry_fire", 8'(dry_fire), 8'h00);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Reset and start.
        cycles(4);
        check("pre_start_control", 8'(control), 8'h02);
        pulse_round_start();
        check("start_control",  8'(control),  8'h00);
        check("start_reload_n", 8'(reload_n), 8'h00);
        cycles(1);
        check("start_reload_rel", 8'(reload_n), 8'h01);

        // Full round: three presses spaced 20 cycles apart.
        rec_q.delete();
        s0 = shot_cnt;
        rec_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            press(3);
            if (i == 0) check("shot1_latency", 8'(control), 8'h01);
            cycles(17);
        end
        rec_en = 1'b0;
        check("round_seq_len", 8'(rec_q.size()), 8'd7);
        for (int i = 0; i < 7 && i < rec_q.size(); i++)
            check($sformatf("round_seq[%0d]", i), 8'(rec_q[i]), 8'(exp_seq[i]));
        check("round_shots", 8'(shot_cnt - s0), 8'd3);
        check("round_empty", 8'(out_of_ammo), 8'h01);

        // Dry fire, then reload.
        press(1);
        cycles(2);
        check("dry_pulse",   8'(dry_fire), 8'h01);
        check("dry_control", 8'(control),  8'h03);
        cycles(1);
        check("dry_end", 8'(dry_fire), 8'h00);
        pulse_round_start();
        check("reload_control",  8'(control),  8'h00);
        check("reload_reload_n", 8'(reload_n), 8'h00);

        // Cooldown: second press lands while cool is still counting down.
        cycles(3);
        press(3);
        check("cd_shot1", 8'(control), 8'h01);
        cycles(1);
        press(1);
        cycles(5);
        check("cd_ignored", 8'(control), 8'h05);
        cycles(5);
        press(3);
        check("cd_shot2", 8'(control), 8'h04);

        // round_start during SHOT2 overrides; cool must restart at zero.
        pulse_round_start();
        check("ovr_control",  8'(control),  8'h00);
        check("ovr_reload_n", 8'(reload_n), 8'h00);
        press(3);
        check("ovr_cool_clear", 8'(control), 8'h01);

        // Held trigger yields a single shot.
        cycles(2);
        pulse_round_start();
        s0 = shot_cnt;
        trigger = 1'b1;
        cycles(50);
        trigger = 1'b0;
        cycles(3);
        check("held_control", 8'(control), 8'h05);
        check("held_shots",   8'(shot_cnt - s0), 8'd1);

        // Asynchronous reset in HOLD3.
        press(3);
        check("h3_shot2", 8'(control), 8'h04);
        cycles(1);
        check("h3_hold", 8'(control), 8'h06);
        #2 reset_n = 1'b0;
        #1;
        check("async_control",  8'(control),    8'h02);
        check("async_reload_n", 8'(reload_n),   8'h01);
        check("async_shot",     8'(shot_fired), 8'h00);
        check("async_empty",    8'(out_of_ammo), 8'h00);
        cycles(1);
        reset_n = 1'b1;
        cycles(3);
        check("post_rst_control", 8'(control), 8'h02);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/firing_control.md
# firing_control

Sequencing controller for the three-shot firing datapath. It turns a raw trigger level and a round-start pulse into the 3-bit `control` state code that the datapath decodes. It generates the datapath's active-low reload pulse, enforces a minimum cooldown between shots, and reports shot, empty and dry-fire events to the game/audio logic. It sits between the trigger input (KEY/light-gun) and the firing datapath, one instance per player.

## Interface
- `COOLDOWN_CYCLES`, default 4: minimum HOLD cycles after a SHOT before the next trigger edge is accepted. Legal range 1..255.
- `clk`  input  1  system clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `trigger`  input  1  raw trigger level, active-high, asynchronous to `clk`.
- `round_start`  input  1  synchronous one-cycle pulse: begin or reload a round.
- `control`  output  3  state code to the firing datapath (encodings below).
- `reload_n`  output  1  registered active-low pulse, one cycle. Wired (ANDed) into the datapath reset to restore 3 shots.
- `shot_fired`  output  1  high exactly during SHOT1/SHOT2/SHOT3 cycles.
- `out_of_ammo`  output  1  high while in OUT.
- `dry_fire`  output  1  registered one-cycle pulse when the trigger is pulled while in OUT.

## Operation
- **Trigger conditioning.**
  - Two-flop synchronizer `s1`, `s2`, plus a delay flop `d`.
  - `edge = s2 & ~d`.
  - Holding the trigger produces exactly one edge.
- **FSM states and `control` encodings.** `control` is the state register, driven directly.
  - PRELOAD=010, HOLD1=000, SHOT1=001, HOLD2=101, SHOT2=100, HOLD3=110, SHOT3=111, OUT=011.
- **Transitions.** Priority is `round_start` first, then the rules below.
  - PRELOAD: stay until `round_start`.
  - HOLD1→SHOT1, HOLD2→SHOT2, HOLD3→SHOT3 on `edge` when `cool == 0`. Otherwise stay.
  - SHOT1→HOLD2, SHOT2→HOLD3, SHOT3→OUT, unconditionally after 1 cycle.
  - OUT: stay. On `edge`, pulse `dry_fire`.
- **`round_start` (any state, including SHOTx and PRELOAD).**
  - Next state is HOLD1.
  - `cool` is cleared to 0.
  - `reload_n` is driven low for the following cycle.
  - A coincident `edge` is dropped.
- **Cooldown counter `cool`** (8 bits).
  - Loaded with `COOLDOWN_CYCLES` on the edge entering any SHOTx.
  - Decrements by 1 every cycle while nonzero; saturates at 0.
- **Dropped edges.** Edges arriving in PRELOAD, in SHOTx, or in HOLDx with `cool != 0` are discarded, never queued.
- **Reset values.**
  - `control` = 010 (PRELOAD); `reload_n` = 1.
  - `shot_fired`, `out_of_ammo`, `dry_fire` = 0.
  - `cool`, `s1`, `s2`, `d` = 0.
  - Reset is asynchronous and may occur mid-round; outputs return to reset values immediately.

## Timing
- **Trigger latency.** `trigger` first sampled high at edge n → `edge` true in cycle n+1..n+2 → `control` = SHOTx after edge n+2.
- **SHOT duration.** Every SHOTx lasts exactly one cycle. The datapath registers the new shot count on the edge leaving SHOTx.
- **Minimum shot spacing.** Fastest shot-to-shot spacing is `COOLDOWN_CYCLES` + 1 cycles (SHOT cycle included), provided a fresh edge is available.
- **Reload timing.** `round_start` high in cycle k:
  - `control` = 000 and `reload_n` = 0 after edge k+1.
  - `reload_n` = 1 after edge k+2.
  - If k is a SHOTx cycle, the datapath's update at edge k+1 is overridden by the async reload.
- **Dry fire.** `dry_fire` is high for the one cycle after the edge at which OUT sampled `edge`.
- **`shot_fired` / `out_of_ammo`.** Moore decodes of state; zero added latency relative to `control`.

## Test plan
- **Reset and start.** Release `reset_n`, then pulse `round_start` at cycle 5 → `control` 010 until edge 6, then 000. `reload_n` low only for the cycle after edge 6.
- **Full round.** Three trigger presses, each 3 cycles long, spaced 20 cycles apart → `control` sequence 000,001,101,100,110,111,011. `shot_fired` gives exactly three 1-cycle pulses. `out_of_ammo` = 1 after SHOT3.
- **Cooldown.** With `COOLDOWN_CYCLES` = 4, a second press 2 cycles after SHOT1 → ignored, `control` stays 101. A third press 10 cycles later → SHOT2.
- **Held trigger.** Hold `trigger` high for 50 cycles in HOLD1 → exactly one SHOT1, then `control` stays 101.
- **Dry fire and reload.**
  - In OUT, press trigger → `dry_fire` one-cycle pulse; `control` stays 011.
  - Then `round_start` → 000 with a `reload_n` pulse.
- **Overrides.**
  - `round_start` coincident with SHOT2 → next `control` 000; `reload_n` low one cycle; `cool` = 0.
  - Assert `reset_n` low mid-HOLD3 → `control` 010 with no clock edge required.
